axis_rr_arbiter: RTL



---
 rtl/axis_arb_pkg.sv | 44 ++++
 rtl/rr_priority_select.sv | 32 +++
 rtl/axis_rr_arbiter.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/axis_arb_pkg.sv
`default_nettype none
// ============================================================================
// Package     : axis_arb_pkg
// Description : Shared types and helpers for the AXI-Stream round-robin
//               arbiter: FSM state encoding and the circular next-grant search.
// Revision    : 1.0 - initial release
// ============================================================================
package axis_arb_pkg;

  // Upper bound on the number of sources the circular search can scan.
  localparam int unsigned c_MAX_SRC = 32;

  typedef enum logic [0:0] {
    ARB_IDLE  = 1'b0,
    ARB_BURST = 1'b1
  } arb_state_t;

  // Return the first set bit of req, scanning circularly from last_grant+1.
  // The source that was served last is visited last, which gives it the
  // lowest priority. When req is empty, last_grant is returned unchanged.
  function automatic int unsigned rr_next(
    input logic [c_MAX_SRC-1:0] req,
    input int unsigned          last_grant,
    input int unsigned          num_src
  );
    int unsigned idx;
    logic        found;
    rr_next = last_grant;
    found   = 1'b0;
    for (int unsigned k = 1; k <= c_MAX_SRC; k++) begin
      // last_grant < num_src and k <= num_src, so one subtraction wraps it
      idx = last_grant + k;
      if (idx >= num_src) begin
        idx = idx - num_src;
      end
      if (!found && (k <= num_src) && (((req >> idx) & 32'd1) != 32'd0)) begin
        rr_next = idx;
        found   = 1'b1;
      end
    end
  endfunction

endpackage
`default_nettype wire

// File: rtl/rr_priority_select.sv
`default_nettype none
// ============================================================================
// Module      : rr_priority_select
// Description : Combinational circular priority encoder. Picks the first
//               asserted request after last_grant, wrapping around.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_priority_select
  import axis_arb_pkg::*;
#(
  parameter int unsigned NUM_SRC   = 4,
  parameter int unsigned SRC_WIDTH = 2
) (
  input  logic [NUM_SRC-1:0]   req,
  input  logic [SRC_WIDTH-1:0] last_grant,
  output logic [SRC_WIDTH-1:0] sel,
  output logic                 any
);

  logic [c_MAX_SRC-1:0] w_req_ext;

  // Zero-extend the request vector to the fixed width the search helper scans.
  always_comb begin
    w_req_ext              = '0;
    w_req_ext[NUM_SRC-1:0] = req;
  end

  assign sel = SRC_WIDTH'(rr_next(w_req_ext, 32'(last_grant), NUM_SRC));
  assign any = |req;

endmodule
`default_nettype wire

// File: rtl/axis_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : axis_rr_arbiter
// Description : Packet-granular round-robin arbiter merging NUM_SRC
//               AXI-Stream sources onto one registered AXI-Stream master.
//               A granted source owns the output until its tlast beat; the
//               source index is carried on m_axis_tid.
// Revision    : 1.0 - initial release
// ============================================================================
module axis_rr_arbiter
  import axis_arb_pkg::*;
#(
  parameter  int unsigned AXIS_BUS_WIDTH = 16,
  parameter  int unsigned NUM_SRC        = 4,
  localparam int unsigned SRC_WIDTH      = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
  input  logic                              m_axi_aclk,
  input  logic                              m_axi_aresetn,
  input  logic [NUM_SRC*AXIS_BUS_WIDTH-1:0] s_axis_tdata,
  input  logic [NUM_SRC-1:0]                s_axis_tvalid,
  input  logic [NUM_SRC-1:0]                s_axis_tlast,
  output logic [NUM_SRC-1:0]                s_axis_tready,
  output logic [AXIS_BUS_WIDTH-1:0]         m_axis_tdata,
  output logic                              m_axis_tvalid,
  output logic                              m_axis_tlast,
  output logic [SRC_WIDTH-1:0]              m_axis_tid,
  input  logic                              m_axis_tready,
  output logic                              busy,
  output logic [SRC_WIDTH-1:0]              grant
);

  arb_state_t                r_state;
  arb_state_t                w_state_nxt;
  logic [SRC_WIDTH-1:0]      r_grant;
  logic [SRC_WIDTH-1:0]      r_last_grant;
  logic [SRC_WIDTH-1:0]      w_sel;
  logic                      w_any;

  logic [AXIS_BUS_WIDTH-1:0] w_src_data [NUM_SRC];
  logic [AXIS_BUS_WIDTH-1:0] w_grant_data;
  logic                      w_grant_valid;
  logic                      w_grant_last;

  logic                      w_out_room;
  logic                      w_accept;
  logic                      w_burst;
  logic [NUM_SRC-1:0]        w_tready;

  logic [AXIS_BUS_WIDTH-1:0] r_m_tdata;
  logic                      r_m_tvalid;
  logic                      r_m_tlast;
  logic [SRC_WIDTH-1:0]      r_m_tid;

  // Unpack the flat source data bus into one word per source.
  generate
    for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src_slice
      assign w_src_data[gi] = s_axis_tdata[gi*AXIS_BUS_WIDTH +: AXIS_BUS_WIDTH];
    end
  endgenerate

  rr_priority_select #(
    .NUM_SRC   (NUM_SRC),
    .SRC_WIDTH (SRC_WIDTH)
  ) u_rr_sel (
    .req        (s_axis_tvalid),
    .last_grant (r_last_grant),
    .sel        (w_sel),
    .any        (w_any)
  );

  // Route the granted source's valid/last/data toward the output stage.
  always_comb begin
    w_grant_data  = '0;
    w_grant_valid = 1'b0;
    w_grant_last  = 1'b0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      if (r_grant == SRC_WIDTH'(i)) begin
        w_grant_data  = w_src_data[i];
        w_grant_valid = s_axis_tvalid[i];
        w_grant_last  = s_axis_tlast[i];
      end
    end
  end

  // The output stage can take a beat when empty or draining this cycle.
  assign w_out_room = ~r_m_tvalid | m_axis_tready;
  assign w_accept   = w_burst & w_grant_valid & w_out_room;

  // State register.
  always_ff @(posedge m_axi_aclk or negedge m_axi_aresetn) begin
    if (!m_axi_aresetn) begin
      r_state <= ARB_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic: arbitrate in IDLE, hold the grant until tlast is taken.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ARB_IDLE:  if (w_any) w_state_nxt = ARB_BURST;
      ARB_BURST: if (w_accept && w_grant_last) w_state_nxt = ARB_IDLE;
      default:   w_state_nxt = ARB_IDLE;
    endcase
  end

  // State outputs: only the granted source sees tready, and only in BURST.
  always_comb begin
    w_burst  = 1'b0;
    w_tready = '0;
    if (r_state == ARB_BURST) begin
      w_burst = 1'b1;
      for (int unsigned i = 0; i < NUM_SRC; i++) begin
        w_tready[i] = w_out_room && (r_grant == SRC_WIDTH'(i));
      end
    end
  end

  // Grant bookkeeping: latch the winner in IDLE, remember it once its packet ends.
  always_ff @(posedge m_axi_aclk or negedge m_axi_aresetn) begin
    if (!m_axi_aresetn) begin
      r_grant      <= '0;
      r_last_grant <= SRC_WIDTH'(NUM_SRC - 1);
    end else begin
      if ((r_state == ARB_IDLE) && w_any) begin
        r_grant <= w_sel;
      end
      if (w_accept && w_grant_last) begin
        r_last_grant <= r_grant;
      end
    end
  end

  // One-entry output register: load on accept, clear valid on a pure drain.
  always_ff @(posedge m_axi_aclk or negedge m_axi_aresetn) begin
    if (!m_axi_aresetn) begin
      r_m_tdata  <= '0;
      r_m_tvalid <= 1'b0;
      r_m_tlast  <= 1'b0;
      r_m_tid    <= '0;
    end else if (w_accept) begin
      r_m_tdata  <= w_grant_data;
      r_m_tvalid <= 1'b1;
      r_m_tlast  <= w_grant_last;
      r_m_tid    <= r_grant;
    end else if (r_m_tvalid && m_axis_tready) begin
      r_m_tvalid <= 1'b0;
    end
  end

  assign s_axis_tready = w_tready;
  assign m_axis_tdata  = r_m_tdata;
  assign m_axis_tvalid = r_m_tvalid;
  assign m_axis_tlast  = r_m_tlast;
  assign m_axis_tid    = r_m_tid;
  assign busy          = w_burst;
  assign grant         = r_grant;

endmodule
`default_nettype wire
